uart_bus_ctrl: RTL and testbench

- Sequences the on-board UART and shares the 8-bit data bus it has in common with base SRAM.
- Gives the core a valid/ready TX stream and a one-entry buffered RX stream.
- Generates the uart_rdn/uart_wrn strobes and waits on tbre/tsre/data_ready.
- Arbitrates bus ownership against an SRAM requester, so the UART and the RAM never drive the bus together.

---
 rtl/uart_bus_pkg.sv | 27 ++
 rtl/uart_bus_arb.sv | 32 +++
 rtl/uart_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART / SRAM shared-bus controller.
//   state_t    : controller FSM states
//   STROBE_OFF : inactive level of the active-low UART strobes
//   CNT_W      : width of the strobe-length counter (holds up to 15)
//   WIN_*      : encodings of the IDLE arbitration winner
package uart_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_LOW_S  = 3'd1,
        WR_SETUP  = 3'd2,
        WR_PULSE  = 3'd3,
        WR_HOLD   = 3'd4,
        WAIT_TBRE = 3'd5,
        WAIT_TSRE = 3'd6,
        RAM       = 3'd7
    } state_t;

    localparam logic STROBE_OFF = 1'b1;
    localparam int   CNT_W      = 4;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_RAM  = 2'd1;
    localparam logic [1:0] WIN_RX   = 2'd2;
    localparam logic [1:0] WIN_TX   = 2'd3;

endpackage

// File: rtl/uart_bus_arb.sv
// Combinational winner select used while the controller sits in IDLE.
//   ram_req  : SRAM controller wants the bus
//   last_ram : previous grant went to RAM (gives the UART a turn next)
//   rx_elig  : UART holds a byte and the RX buffer is empty
//   tx_valid : core has a byte to send
//   win      : WIN_NONE / WIN_RAM / WIN_RX / WIN_TX
module uart_bus_arb
    import uart_bus_pkg::*;
(
    input  logic       ram_req,
    input  logic       last_ram,
    input  logic       rx_elig,
    input  logic       tx_valid,
    output logic [1:0] win
);

    // RAM jumps the queue only if it did not have the previous turn; otherwise
    // the fixed order rx > tx > ram applies, so neither side can starve.
    always_comb begin
        win = WIN_NONE;
        if (ram_req && !last_ram) begin
            win = WIN_RAM;
        end else if (rx_elig) begin
            win = WIN_RX;
        end else if (tx_valid) begin
            win = WIN_TX;
        end else if (ram_req) begin
            win = WIN_RAM;
        end
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// UART sequencer sharing an 8-bit data bus with base SRAM.
//   clk, rst          : clock, asynchronous active-high reset
//   tx_valid/ready    : TX byte stream from the core (tx_ready is combinational)
//   tx_data           : byte to send
//   rx_valid/ready    : one-entry RX buffer handshake towards the core
//   rx_data, rx_err   : received byte and its framing|parity flag
//   ram_req, ram_gnt  : SRAM bus request / grant (no UART activity while granted)
//   bus_data          : shared bidirectional data bus
//   uart_rdn/uart_wrn : active-low UART read / write strobes
//   uart_tbre, uart_tsre, uart_data_ready,
//   uart_framing_error, uart_parity_error : UART status inputs
module uart_bus_ctrl
    import uart_bus_pkg::*;
#(
    parameter int RD_LOW = 2,
    parameter int WR_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    input  logic       rx_ready,
    input  logic       ram_req,
    output logic       ram_gnt,
    inout  wire  [7:0] bus_data,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_tbre,
    input  logic       uart_tsre,
    input  logic       uart_data_ready,
    input  logic       uart_framing_error,
    input  logic       uart_parity_error
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LOW - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LOW - 1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             last_ram;
    logic [7:0]       wr_byte;
    logic             bus_oe;
    logic             rx_elig;
    logic [1:0]       win;
    logic             rd_done;
    logic             rdn_d;
    logic             wrn_d;
    logic             gnt_d;
    logic             oe_d;

    assign rx_elig  = uart_data_ready && !rx_valid;
    assign tx_ready = (state == IDLE) && (win == WIN_TX);
    assign rd_done  = (state == RD_LOW_S) && (cnt == RD_LAST);
    assign bus_data = bus_oe ? wr_byte : {8{1'bz}};

    uart_bus_arb u_arb (
        .ram_req  (ram_req),
        .last_ram (last_ram),
        .rx_elig  (rx_elig),
        .tx_valid (tx_valid),
        .win      (win)
    );

    // Next-state logic. The counter restarts whenever the state changes, so
    // in RD_LOW_S / WR_PULSE it reads 0 on the first low-strobe cycle.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                case (win)
                    WIN_RAM: state_d = RAM;
                    WIN_RX:  state_d = RD_LOW_S;
                    WIN_TX:  state_d = WR_SETUP;
                    default: state_d = IDLE;
                endcase
            end
            RD_LOW_S:  if (cnt == RD_LAST) state_d = IDLE;
            WR_SETUP:  state_d = WR_PULSE;
            WR_PULSE:  if (cnt == WR_LAST) state_d = WR_HOLD;
            WR_HOLD:   state_d = WAIT_TBRE;
            WAIT_TBRE: if (uart_tbre) state_d = WAIT_TSRE;
            WAIT_TSRE: if (uart_tsre) state_d = IDLE;
            RAM:       if (!ram_req) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state; registered below so every bus-side
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        rdn_d = STROBE_OFF;
        wrn_d = STROBE_OFF;
        gnt_d = 1'b0;
        oe_d  = 1'b0;
        case (state_d)
            RD_LOW_S: rdn_d = ~STROBE_OFF;
            WR_SETUP: oe_d  = 1'b1;
            WR_PULSE: begin
                oe_d  = 1'b1;
                wrn_d = ~STROBE_OFF;
            end
            WR_HOLD:  oe_d  = 1'b1;
            RAM:      gnt_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            uart_rdn <= STROBE_OFF;
            uart_wrn <= STROBE_OFF;
            ram_gnt  <= 1'b0;
            bus_oe   <= 1'b0;
            last_ram <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= (state_d == state) ? cnt + 1'b1 : '0;
            uart_rdn <= rdn_d;
            uart_wrn <= wrn_d;
            ram_gnt  <= gnt_d;
            bus_oe   <= oe_d;

            if (state == IDLE) begin
                if (win == WIN_RAM) begin
                    last_ram <= 1'b1;
                end else if (win == WIN_RX || win == WIN_TX) begin
                    last_ram <= 1'b0;
                end
            end

            // Sample on the last low cycle of uart_rdn, while the UART still drives.
            if (rd_done) begin
                rx_valid <= 1'b1;
                rx_data  <= bus_data;
                rx_err   <= uart_framing_error | uart_parity_error;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Outgoing byte: datapath only, loaded on TX acceptance.
    always_ff @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            wr_byte <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;
    import uart_bus_pkg::*;

    localparam int RD_LOW   = 2;
    localparam int WR_LOW   = 1;
    localparam int LIMIT    = 60;
    localparam int TBRE_AT  = 8;
    localparam int TSRE_AT  = 11;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_ready;
    logic       ram_req;
    logic       ram_gnt;
    wire  [7:0] bus_data;
    logic       uart_rdn;
    logic       uart_wrn;
    logic       tbre;
    logic       tsre;
    logic       data_ready;
    logic       fe;
    logic       pe;
    logic [7:0] ub;

    int checks = 0;
    int errors = 0;

    logic [8:0] rx_q[$];
    logic [7:0] tx_q[$];
    byte        ev_q[$];

    // UART model: presents its byte while the read strobe is low.
    assign bus_data = uart_rdn ? {8{1'bz}} : ub;

    uart_bus_ctrl #(.RD_LOW(RD_LOW), .WR_LOW(WR_LOW)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .rx_valid           (rx_valid),
        .rx_data            (rx_data),
        .rx_err             (rx_err),
        .rx_ready           (rx_ready),
        .ram_req            (ram_req),
        .ram_gnt            (ram_gnt),
        .bus_data           (bus_data),
        .uart_rdn           (uart_rdn),
        .uart_wrn           (uart_wrn),
        .uart_tbre          (tbre),
        .uart_tsre          (tsre),
        .uart_data_ready    (data_ready),
        .uart_framing_error (fe),
        .uart_parity_error  (pe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 ram_gnt, 1 uart_rdn low, 2 tx_ready, 3 rx_valid, other uart_wrn low
    task automatic wait_for(input int kind, input string name, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n <= LIMIT) begin
            @(negedge clk);
            case (kind)
                0:       hit = ram_gnt;
                1:       hit = !uart_rdn;
                2:       hit = tx_ready;
                3:       hit = rx_valid;
                default: hit = !uart_wrn;
            endcase
            if (!hit) n++;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=no_event required=event_within_%0d_cycles", name, LIMIT);
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n;
        tx_data  = b;
        tx_valid = 1'b1;
        tx_q.push_back(b);
        wait_for(2, "tx_accept", n);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] b, input logic f, input logic p);
        int n;
        @(posedge clk); #1;
        ub         = b;
        fe         = f;
        pe         = p;
        data_ready = 1'b1;
        rx_q.push_back({f | p, b});
        wait_for(1, "rd_start", n);
        data_ready = 1'b0;
        wait_for(3, "rd_valid", n);
        @(posedge clk); #1;
        fe = 1'b0;
        pe = 1'b0;
    endtask

    // Monitor: pops the scoreboards when the DUT presents data and watches bus ownership.
    initial begin
        logic       prev_wrn;
        logic       prev_rdn;
        logic       prev_gnt;
        logic [7:0] prev_bus;
        logic [7:0] exp_wr;
        logic [8:0] e;
        int         wlen;
        int         rlen;
        prev_wrn = 1'b1;
        prev_rdn = 1'b1;
        prev_gnt = 1'b0;
        prev_bus = 8'h00;
        exp_wr   = 8'h00;
        wlen     = 0;
        rlen     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wrn = 1'b1;
                prev_rdn = 1'b1;
                prev_gnt = 1'b0;
                wlen     = 0;
                rlen     = 0;
            end else begin
                if (rx_valid && rx_ready) begin
                    if (rx_q.size() == 0) begin
                        check("rx_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = rx_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e[7:0]));
                        check("rx_err", 32'(rx_err), 32'(e[8]));
                    end
                end
                if (!uart_wrn) begin
                    if (prev_wrn) begin
                        if (tx_q.size() == 0) begin
                            check("tx_unexpected", 32'd1, 32'd0);
                            exp_wr = 8'h00;
                        end else begin
                            exp_wr = tx_q.pop_front();
                        end
                        check("wr_setup_data", 32'(prev_bus), 32'(exp_wr));
                        wlen = 0;
                        ev_q.push_back("W");
                    end
                    wlen++;
                    check("wr_pulse_data", 32'(bus_data), 32'(exp_wr));
                end else if (!prev_wrn) begin
                    check("wr_low_len", 32'(wlen), 32'(WR_LOW));
                    check("wr_hold_data", 32'(bus_data), 32'(exp_wr));
                end
                if (!uart_rdn) begin
                    if (prev_rdn) begin
                        rlen = 0;
                        ev_q.push_back("R");
                    end
                    rlen++;
                    check("rdn_vs_wrn", 32'(uart_wrn), 32'd1);
                end else if (!prev_rdn) begin
                    check("rd_low_len", 32'(rlen), 32'(RD_LOW));
                end
                if (ram_gnt && !prev_gnt) ev_q.push_back("G");
                if (ram_gnt) begin
                    check("gnt_vs_rdn", 32'(uart_rdn), 32'd1);
                    check("gnt_vs_wrn", 32'(uart_wrn), 32'd1);
                end
                prev_wrn = uart_wrn;
                prev_rdn = uart_rdn;
                prev_gnt = ram_gnt;
                prev_bus = bus_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         lows;
        logic [31:0] order;

        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rx_ready   = 1'b1;
        ram_req    = 1'b0;
        tbre       = 1'b1;
        tsre       = 1'b1;
        data_ready = 1'b0;
        fe         = 1'b0;
        pe         = 1'b0;
        ub         = 8'h00;

        // Reset values
        @(posedge clk); #1;
        check("rst_rdn", 32'(uart_rdn), 32'd1);
        check("rst_wrn", 32'(uart_wrn), 32'd1);
        check("rst_gnt", 32'(ram_gnt), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset in the middle of the write pulse
        @(posedge clk); #1;
        send_tx(8'h96);
        wait_for(4, "wr_low_a", n);
        #1 rst = 1'b1;
        #1;
        check("rst_async_wrn", 32'(uart_wrn), 32'd1);
        check("rst_async_rdn", 32'(uart_rdn), 32'd1);
        check("rst_async_gnt", 32'(ram_gnt), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_state_idle", 32'(dut.state), 32'(IDLE));

        // Read of 8'h41, buffer held full, then released
        @(posedge clk); #1;
        rx_ready   = 1'b0;
        ub         = 8'h41;
        data_ready = 1'b1;
        rx_q.push_back({1'b0, 8'h41});
        wait_for(3, "rd_b", n);
        check("rd_latency", 32'(n), 32'(RD_LOW + 1));
        ub = 8'h42;
        rx_q.push_back({1'b0, 8'h42});
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!uart_rdn) lows++;
        end
        check("no_read_while_full", 32'(lows), 32'd0);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_for(1, "rd_after_release", n);
        check("rd_restart_delay", 32'(n), 32'd2);
        data_ready = 1'b0;
        wait_for(3, "rd_b2", n);
        @(posedge clk); #1;

        // TX 8'h5A with delayed tbre/tsre, back-to-back byte queued behind it
        tbre     = 1'b0;
        tsre     = 1'b0;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tx_q.push_back(8'h5A);
        wait_for(2, "tx_c", n);
        @(posedge clk); #1;
        tx_data = 8'hB4;
        tx_q.push_back(8'hB4);
        n = 1;
        while (n <= LIMIT) begin
            @(negedge clk);
            if (tx_ready) break;
            if (n == TBRE_AT) tbre = 1'b1;
            if (n == TSRE_AT) tsre = 1'b1;
            n++;
        end
        check("tx_busy_cycles", 32'(n), 32'(TSRE_AT + 1));
        @(posedge clk); #1;
        tx_data = 8'h0F;
        tx_q.push_back(8'h0F);
        n = 1;
        while (n <= LIMIT) begin
            @(negedge clk);
            if (tx_ready) break;
            n++;
        end
        check("tx_min_cycles", 32'(n), 32'(WR_LOW + 5));
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // RAM, RX and TX all requesting at once
        ev_q.delete();
        ram_req    = 1'b1;
        tx_data    = 8'hA5;
        tx_valid   = 1'b1;
        tx_q.push_back(8'hA5);
        ub         = 8'h77;
        data_ready = 1'b1;
        rx_q.push_back({1'b0, 8'h77});
        check("arb_tx_held", 32'(tx_ready), 32'd0);
        wait_for(0, "gnt1", n);
        ram_req = 1'b0;
        @(posedge clk); #1;
        ram_req = 1'b1;
        wait_for(1, "arb_rd", n);
        data_ready = 1'b0;
        wait_for(0, "gnt2", n);
        ram_req = 1'b0;
        wait_for(2, "arb_tx", n);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("arb_event_count", 32'(ev_q.size()), 32'd4);
        if (ev_q.size() >= 4) begin
            order = {ev_q[0], ev_q[1], ev_q[2], ev_q[3]};
            check("arb_order", order, 32'h47524757);
        end

        // Error flags captured with the byte
        do_read(8'hFF, 1'b0, 1'b1);
        do_read(8'h3C, 1'b0, 1'b0);
        do_read(8'h00, 1'b1, 1'b0);

        // TX proceeds while the RX buffer is full; read resumes after release
        rx_ready = 1'b0;
        do_read(8'h11, 1'b0, 1'b0);
        ub         = 8'h22;
        data_ready = 1'b1;
        rx_q.push_back({1'b0, 8'h22});
        tx_data    = 8'hC7;
        tx_valid   = 1'b1;
        tx_q.push_back(8'hC7);
        wait_for(2, "tx_while_full", n);
        check("tx_ready_while_full", 32'(tx_ready), 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!uart_rdn) lows++;
        end
        check("no_read_while_full_tx", 32'(lows), 32'd0);
        check("rx_still_valid", 32'(rx_valid), 32'd1);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_for(1, "rd_after_release_f", n);
        check("rd_restart_delay_f", 32'(n), 32'd2);
        data_ready = 1'b0;
        wait_for(3, "rd_f2", n);
        repeat (5) @(posedge clk);
        #1;

        check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
